// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-rate arithmetic.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Three in-bit sample offsets, counted in clk cycles from the start of a bit.
  typedef struct packed {
    int s1;
    int s2;
    int s3;
  } sample_pts_t;

  // Clock cycles per line bit, rounded up so the bit period is never short.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud - 1) / baud;
  endfunction

  // Quarter, half and three-quarter points of a bit period.
  function automatic sample_pts_t sample_points(input int cpb);
    sample_pts_t sp;
    sp.s1 = cpb / 4;
    sp.s2 = cpb / 2;
    sp.s3 = (3 * cpb) / 4;
    return sp;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handshake between uart_rx (master) and its consumer (slave).
// Handshake: a byte transfers on every clk edge where rx_valid && rx_rdy.
// rx_valid, once high, stays high with rx_data unchanged until that transfer;
// rx_rdy may change freely and never depends on a combinational path to rx_valid.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_valid;
  logic                 rx_rdy;
  logic [DATA_BITS-1:0] rx_data;

  modport master (output rx_valid, output rx_data, input rx_rdy);
  modport slave  (input rx_valid, input rx_data, output rx_rdy);
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit-period timer and 3-sample majority vote for the UART receiver.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int BAUD_RATE     = 115200,
  parameter int CLK_FREQUENCY = 48000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,      // high while a frame is being received
  input  logic rx_s,     // synchronised serial line
  output logic bit_vld,  // third sample point: bit_val is the decided bit
  output logic bit_val,
  output logic bit_end   // last cycle of the current bit period
);

  localparam int          CPB   = clks_per_bit(CLK_FREQUENCY, BAUD_RATE);
  localparam int          CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam sample_pts_t SP    = sample_points(CPB);

  localparam logic [CNT_W-1:0] S1   = CNT_W'(SP.s1);
  localparam logic [CNT_W-1:0] S2   = CNT_W'(SP.s2);
  localparam logic [CNT_W-1:0] S3   = CNT_W'(SP.s3);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CPB - 1);

  logic [CNT_W-1:0] bit_cnt;
  logic             samp1;
  logic             samp2;

  // Bit-period counter: parked at 0 while idle, wraps every CPB cycles.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      bit_cnt <= '0;
    end else if (bit_cnt == LAST) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Hold the first two samples; the third is taken live at S3 so the
  // decision is available in the same cycle as the third sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp1 <= 1'b1;
      samp2 <= 1'b1;
    end else begin
      if (run && bit_cnt == S1) samp1 <= rx_s;
      if (run && bit_cnt == S2) samp2 <= rx_s;
    end
  end

  // Majority vote and period strobes.
  always_comb begin
    bit_vld = run && (bit_cnt == S3);
    bit_end = run && (bit_cnt == LAST);
    bit_val = (samp1 & samp2) | (samp1 & rx_s) | (samp2 & rx_s);
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1-style frames: synchroniser, start/stop validation,
// LSB-first deserialiser and a 1-entry valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE     = 115200,
  parameter int CLK_FREQUENCY = 48000000,
  parameter int DATA_BITS     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_uart,
  uart_rx_if.master  rx_if,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun_err,
  output rx_state_t  dbg_state
);

  localparam int             IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_t            state, state_n;
  logic [1:0]           sync;
  logic [1:0]           sync_fill;
  logic                 rx_s;
  logic                 armed;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;
  logic                 valid_q;
  logic [DATA_BITS-1:0] data_q;

  logic bit_vld, bit_val, bit_end;
  logic idx_clr, idx_inc, shift_wr;
  logic go_load, go_ferr, go_oerr;

  assign rx_s           = sync[1];
  assign rx_busy        = (state != RX_IDLE);
  assign dbg_state      = state;
  assign rx_if.rx_valid = valid_q;
  assign rx_if.rx_data  = data_q;

  uart_rx_sampler #(
    .BAUD_RATE     (BAUD_RATE),
    .CLK_FREQUENCY (CLK_FREQUENCY)
  ) u_sampler (
    .clk     (clk),
    .reset   (reset),
    .run     (rx_busy),
    .rx_s    (rx_s),
    .bit_vld (bit_vld),
    .bit_val (bit_val),
    .bit_end (bit_end)
  );

  // Two-stage synchroniser plus arming. The sync stages reset to idle-high,
  // so sync_fill keeps armed clear until rx_s reflects a real line sample;
  // otherwise a line held low through reset would look like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= 2'b11;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync      <= {sync[0], rx_uart};
      sync_fill <= {sync_fill[0], 1'b1};
      if (rx_s && sync_fill[1]) armed <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_n;
  end

  // FSM next state and datapath strobes.
  always_comb begin
    state_n  = state;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    shift_wr = 1'b0;
    go_load  = 1'b0;
    go_ferr  = 1'b0;
    go_oerr  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (armed && !rx_s) state_n = RX_START;
      end
      RX_START: begin
        if (bit_vld && bit_val) begin
          state_n = RX_IDLE;            // start bit did not hold: line noise
        end else if (bit_end) begin
          state_n = RX_DATA;
          idx_clr = 1'b1;
        end
      end
      RX_DATA: begin
        shift_wr = bit_vld;
        if (bit_end) begin
          if (idx == LAST_IDX) state_n = RX_STOP;
          else                 idx_inc = 1'b1;
        end
      end
      RX_STOP: begin
        // Leave at the third sample rather than the bit end, so a start bit
        // that follows immediately is seen from its first cycle.
        if (bit_vld) begin
          state_n = RX_IDLE;
          if (!bit_val)                      go_ferr = 1'b1;
          else if (!valid_q || rx_if.rx_rdy) go_load = 1'b1;
          else                               go_oerr = 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  // Deserialiser: data bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      shift <= '0;
    end else begin
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;
      if (shift_wr)     shift[idx] <= bit_val;
    end
  end

  // Holding register and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= 1'b0;
      data_q         <= '0;
      rx_frame_err   <= 1'b0;
      rx_overrun_err <= 1'b0;
    end else begin
      rx_frame_err   <= go_ferr;
      rx_overrun_err <= go_oerr;
      if (go_load) begin
        data_q  <= shift;
        valid_q <= 1'b1;
      end else if (valid_q && rx_if.rx_rdy) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
